seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Parametrised, runtime-programmable serial sequence detector, the general successor to the fixed 0110 detectors in the FSM library. It matches a pattern of 1..MAXLEN bits on a 1-bit sampled stream, with overlapping or non-overlapping mode and Mealy or Moore output timing. It keeps a saturating match counter and sits on serial monitor paths where the pattern is configured by a controller.

## Interface
- MAXLEN, 8: maximum pattern length in bits (≥2).
- CNTW, 16: match counter width (≥2).
- MEALY, 1: 1 = combinational match output on the final bit; 0 = registered, one cycle later.
- RST_PATTERN, 8'b0000_0110: active pattern after reset (MAXLEN bits).
- RST_LEN, 4: active length after reset.
- RST_OVERLAP, 0: active overlap mode after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  the stream bit `in` is valid this cycle.
- in  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe that captures cfg_* into the active configuration.
- cfg_pattern  in  MAXLEN  pattern; bit [len-1] is received first and bit [0] last.
- cfg_len  in  $clog2(MAXLEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping detection.
- clr  in  1  synchronous clear of the counter, sticky flag and window.
- out  out  1  match pulse.
- match_count  out  CNTW  number of matches since reset or clr.
- count_sat  out  1  sticky; set when the counter saturates.
- cfg_err  out  1  the active length is invalid (0 or >MAXLEN).

## Operation
- **Active configuration registers:** pattern, len, overlap.
- **Reset** loads RST_* into them.
- **cfg_load** copies cfg_* into them and clears hist and fill. It does not touch the counter.
- **Window:** hist[MAXLEN-1:0] and fill, where fill counts valid bits since the last restart and saturates at len.
- **On en with no cfg_load or clr:**
  - hist <= {hist[MAXLEN-2:0], in}.
  - fill <= min(fill+1, len).
- **Match condition (Mealy term m):** en && !cfg_err && fill ≥ len-1 && ({hist,in} low len bits) == pattern low len bits.
- **On m:**
  - If overlap=0, fill <= 0, so the matched bits cannot start another match.
  - If overlap=1, fill stays saturated.
- **Counter:** match_count increments on m. At all-ones it holds and count_sat sets. count_sat stays set until clr or reset.
- **clr:** match_count <= 0, count_sat <= 0, fill <= 0. The active configuration is unchanged.
- **Priority, highest first:** rstn > cfg_load > clr > en.
  - An en bit arriving in a cycle with cfg_load or clr is discarded. It produces no match and no shift.
- **cfg_err:** combinational from the active len. While cfg_err=1, m is forced to 0, but bits still shift.
- **Pattern bits:** bits above len-1 are ignored.

## Timing
- **Reset values:** out=0, match_count=0, count_sat=0, hist=0, fill=0, cfg_err=0 with the default RST_LEN.
- **MEALY=1:**
  - out = m, combinational from en/in in the same cycle as the final pattern bit.
  - The counter updates at that edge.
- **MEALY=0:**
  - out is a register <= m.
  - It is high for exactly one cycle, the cycle after the final bit, and is 0 after reset.
- **Latency:** the earliest match is on the len-th valid bit after reset, clr, cfg_load or a non-overlap match.
- **Gaps in en:** cycles with en=0 leave hist, fill and the counter unchanged. Gaps are transparent to matching.
- **Asynchronous reset mid-stream:** the window is discarded immediately and out drops without waiting for a clock edge.

## Test plan
- **Default config, non-overlap, MEALY=1:**
  - Stimulus: en=1 with in = 0,1,1,0,1,1,0.
  - Required: out high only on bit index 3. match_count=1.
- **Same stream after cfg_load with pattern 0110, len 4, overlap=1:**
  - Required: out high on indexes 3 and 6. match_count=2.
- **MEALY=0, pattern 101, len 3, overlap=1:**
  - Stimulus: 1,0,1,0,1 with en low for 2 cycles between bits 2 and 3.
  - Required: out high one cycle after bits 2 and 4. match_count=2.
- **CNTW=4, pattern 1, len 1, overlap=1:**
  - Stimulus: 17 ones.
  - Required: match_count=15 and count_sat=1 after the 15th one, both holding.
  - Then clr: required match_count=0 and count_sat=0.
- **Invalid length:**
  - cfg_load with len=0: cfg_err=1 and no out for any input.
  - Then cfg_load with len=MAXLEN and an all-ones pattern: out on the MAXLEN-th consecutive one.
- **Same-cycle events:**
  - cfg_load in the same cycle as what would be a final matching bit: no out, and the count is unchanged.
  - rstn pulsed after 3 bits of 0110, then 0,1,1,0: exactly one match, on the 4th post-reset bit.

Source files
------------

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector with overlap and
// Mealy/Moore modes plus a saturating match counter.
module seq_detect_prog #(
    parameter int MAXLEN = 8,
    parameter int CNTW = 16,
    parameter bit MEALY = 1,
    parameter logic [MAXLEN-1:0] RST_PATTERN = 8'b0000_0110,
    parameter int RST_LEN = 4,
    parameter bit RST_OVERLAP = 0,
    localparam int LW = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              in,
    input  logic              cfg_load,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LW-1:0]     cfg_len,
    input  logic              cfg_overlap,
    input  logic              clr,
    output logic              out,
    output logic [CNTW-1:0]   match_count,
    output logic              count_sat,
    output logic              cfg_err
);
    logic [MAXLEN-1:0] pattern, hist, win, mask;
    logic [LW-1:0] len, fill, fill_nx;
    logic [LW:0] fill_inc;
    logic [CNTW-1:0] cnt_nx;
    logic overlap, m;

    assign cfg_err = (len == '0) || (len > LW'(MAXLEN));
    assign win = {hist[MAXLEN-2:0], in};
    assign mask = ~({MAXLEN{1'b1}} << len);
    assign fill_inc = {1'b0, fill} + (LW+1)'(1);
    // rstn gates m so a Mealy out drops as soon as reset asserts
    assign m = rstn && en && !cfg_load && !clr && !cfg_err && fill_inc >= {1'b0, len}
               && (win & mask) == (pattern & mask);
    assign fill_nx = (m && !overlap) ? '0 : (fill_inc > {1'b0, len}) ? len : fill_inc[LW-1:0];
    assign cnt_nx = (&match_count) ? match_count : match_count + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pattern     <= RST_PATTERN;
            len         <= LW'(RST_LEN);
            overlap     <= RST_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= cfg_len;
            overlap <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
        end else if (clr) begin
            match_count <= '0;
            count_sat   <= 1'b0;
            fill        <= '0;
        end else if (en) begin
            hist <= win;
            fill <= fill_nx;
            if (m) begin
                match_count <= cnt_nx;
                count_sat   <= count_sat | (&cnt_nx);
            end
        end
    end

    generate
        if (MEALY) begin : g_mealy
            assign out = m;
        end else begin : g_moore
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) out <= 1'b0;
                else out <= m;
            end
        end
    endgenerate
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed checks of seq_detect_prog in Mealy, Moore and
// narrow-counter builds sharing one stimulus stream.
module tb_seq_detect_prog;
    logic clk = 0, rstn, en, in, cfg_load, cfg_overlap, clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic out1, out0, out4, sat1, sat0, sat4, err1, err0, err4;
    logic [15:0] cnt1, cnt0;
    logic [3:0] cnt4;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.MEALY(1)) u1 (.clk(clk), .rstn(rstn), .en(en), .in(in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr(clr),
        .out(out1), .match_count(cnt1), .count_sat(sat1), .cfg_err(err1));
    seq_detect_prog #(.MEALY(0)) u0 (.clk(clk), .rstn(rstn), .en(en), .in(in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr(clr),
        .out(out0), .match_count(cnt0), .count_sat(sat0), .cfg_err(err0));
    seq_detect_prog #(.MEALY(1), .CNTW(4)) u4 (.clk(clk), .rstn(rstn), .en(en), .in(in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr(clr),
        .out(out4), .match_count(cnt4), .count_sat(sat4), .cfg_err(err4));

    typedef struct {
        string name;
        logic en, in, ld, cl;
        logic [7:0] pat;
        logic [3:0] len;
        logic ov, eo, ee;
        int ec;
    } vec_t;
    vec_t vs[$];
    logic cur_err = 0;

    function automatic void add(string n, logic e, logic i, logic ld, logic cl,
                                logic [7:0] p, logic [3:0] l, logic o, logic eo, int ec);
        vec_t v;
        v = '{n, e, i, ld, cl, p, l, o, eo, cur_err, ec};
        vs.push_back(v);
        if (ld) cur_err = (l == 0) || (l > 8);
    endfunction

    function automatic void bits(string n, logic [15:0] b, logic [15:0] eo, int num, int c0, int c1, int at);
        for (int k = 0; k < num; k++)
            add($sformatf("%s_b%0d", n, k), 1, b[num-1-k], 0, 0, 0, 0, 0, eo[num-1-k], k >= at ? c1 : c0);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic tick(logic e, logic i, logic ld, logic cl, logic [7:0] p, logic [3:0] l, logic o);
        en = e; in = i; cfg_load = ld; clr = cl; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        @(posedge clk); #1;
        en = 0; cfg_load = 0; clr = 0;
    endtask

    logic [6:0] m_en, m_in, m_exp;

    initial begin
        rstn = 0; en = 0; in = 0; cfg_load = 0; clr = 0;
        cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        #12;
        chk("rst_out1", out1, 0); chk("rst_out0", out0, 0);
        chk("rst_cnt1", cnt1, 0); chk("rst_sat1", sat1, 0);
        chk("rst_err1", err1, 0); chk("rst_cnt4", cnt4, 0);
        @(posedge clk); #1; rstn = 1;

        bits("dflt", 16'b0110110, 16'b0001000, 7, 0, 1, 3);
        add("clr_a", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add("ld_ov", 0, 0, 1, 0, 8'b0110, 4, 1, 0, 0);
        bits("ov", 16'b0110110, 16'b0001001, 7, 0, 1, 3);
        vs[$].ec = 2;
        add("clr_b", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add("ld_len0", 0, 0, 1, 0, 8'hA5, 0, 0, 0, 0);
        bits("bad", 16'b101001, 16'b0, 6, 0, 0, 0);
        add("ld_ff", 0, 0, 1, 0, 8'hFF, 8, 0, 0, 0);
        bits("ff", 16'h1FF, 16'b010, 9, 0, 1, 7);
        add("ld_again", 0, 0, 1, 0, 8'b0110, 4, 0, 0, 1);
        bits("pre", 16'b011, 16'b0, 3, 1, 1, 0);
        add("ld_final", 1, 0, 1, 0, 8'b0110, 4, 0, 0, 1);
        bits("post", 16'b0110, 16'b0001, 4, 1, 2, 3);

        for (int k = 0; k < vs.size(); k++) begin
            en = vs[k].en; in = vs[k].in; cfg_load = vs[k].ld; clr = vs[k].cl;
            cfg_pattern = vs[k].pat; cfg_len = vs[k].len; cfg_overlap = vs[k].ov;
            @(negedge clk);
            chk({vs[k].name, "_out"}, out1, vs[k].eo);
            chk({vs[k].name, "_err"}, err1, vs[k].ee);
            @(posedge clk); #1;
            chk({vs[k].name, "_cnt"}, cnt1, vs[k].ec);
        end
        en = 0; cfg_load = 0; clr = 0;

        // async reset three bits into 0110, then a clean 0110
        tick(1, 0, 0, 0, 0, 0, 0); tick(1, 1, 0, 0, 0, 0, 0); tick(1, 1, 0, 0, 0, 0, 0);
        en = 1; in = 0; #2; rstn = 0; #1;
        chk("arst_out", out1, 0); chk("arst_cnt", cnt1, 0);
        @(posedge clk); #1; en = 0; rstn = 1;
        for (int k = 0; k < 4; k++) begin
            en = 1; in = (k == 1 || k == 2);
            @(negedge clk);
            chk($sformatf("prst_b%0d_out", k), out1, k == 3);
            @(posedge clk); #1;
        end
        en = 0;
        chk("prst_cnt", cnt1, 1);

        // Moore build: 101 overlapping with a two-cycle en gap
        tick(0, 0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 8'b101, 3, 1);
        m_en = 7'b1110011; m_in = 7'b1010001; m_exp = 7'b0010001;
        for (int k = 0; k < 7; k++) begin
            tick(m_en[6-k], m_in[6-k], 0, 0, 0, 0, 0);
            chk($sformatf("moore_s%0d_out", k), out0, m_exp[6-k]);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("moore_tail_out", out0, 0);
        chk("moore_cnt", cnt0, 2);

        // 4-bit counter saturation on single-bit pattern
        tick(0, 0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 8'b1, 1, 1);
        for (int k = 1; k <= 17; k++) begin
            tick(1, 1, 0, 0, 0, 0, 0);
            chk($sformatf("sat_%0d_cnt", k), cnt4, k > 15 ? 15 : k);
            chk($sformatf("sat_%0d_flag", k), sat4, k >= 15);
        end
        tick(0, 0, 0, 1, 0, 0, 0);
        chk("sat_clr_cnt", cnt4, 0);
        chk("sat_clr_flag", sat4, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
